// File: rtl/toggle_sync_pkg.sv
// rtl/toggle_sync_pkg.sv - shared types and helpers for the toggle-channel request arbiters
package toggle_sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_e;

    localparam int DEFAULT_ACK_TIMEOUT = 64;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set bit at or after ptr, wrapping
module rr_pick
    import toggle_sync_pkg::*;
#(
    parameter int N = 4,
    parameter int W = id_w(N)
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] id
);

    logic [W-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        valid = |pend;
        id    = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (pend[idx]) id = idx;
        end
    end

endmodule

// File: rtl/toggle_req_arbiter.sv
// rtl/toggle_req_arbiter.sv - round-robin scheduler feeding one toggle-synchronizer channel
module toggle_req_arbiter
    import toggle_sync_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = id_w(N_REQ),
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             ack_pol,
    output logic             tx_pol,
    output logic [ID_W-1:0]  tx_id,
    output logic             busy,
    output logic [N_REQ-1:0] done_pulse,
    output logic [N_REQ-1:0] pend,
    output logic [N_REQ-1:0] coalesce_pulse,
    output logic             ack_late
);

    localparam int              CNT_W   = $clog2(ACK_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    arb_state_e       state_q, state_d;
    logic             pol_q, pol_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] coal_q, coal_d;
    logic [N_REQ-1:0] clr;
    logic             late_q, late_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_pol_q;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;

    rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
        .pend  (pend_q),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_d = state_q;
        pol_d   = pol_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        late_d  = late_q;
        cnt_d   = cnt_q;
        clr     = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_id;
                    state_d = SEND;
                end
            end
            SEND: begin
                pol_d   = ~pol_q;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_pol == pol_q) begin
                    clr     = N_REQ'(1) << id_q;
                    done_d  = clr;
                    ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    late_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if ((ACK_TIMEOUT != 0) && (cnt_d == CNT_MAX)) late_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        // A request landing on its own completion cycle re-arms the bit.
        pend_d = (pend_q & ~clr) | req_pulse;
        coal_d = req_pulse & pend_q & ~clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pol_q     <= 1'b0;
            id_q      <= '0;
            ptr_q     <= '0;
            pend_q    <= '0;
            done_q    <= '0;
            coal_q    <= '0;
            late_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            ack_pol_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pol_q     <= pol_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            coal_q    <= coal_d;
            late_q    <= late_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            ack_pol_q <= ack_pol;
        end
    end

    // The far side may only answer while a transfer is outstanding.
    ack_stable_outside_wait: assert property (@(posedge clk) disable iff (rst)
        (state_q != WAIT_ACK) |-> (ack_pol == ack_pol_q));

    assign tx_pol         = pol_q;
    assign tx_id          = id_q;
    assign busy           = busy_q;
    assign done_pulse     = done_q;
    assign pend           = pend_q;
    assign coalesce_pulse = coal_q;
    assign ack_late       = late_q;

endmodule

// File: tb/tb_toggle_req_arbiter.sv
// tb/tb_toggle_req_arbiter.sv - self-checking bench for toggle_req_arbiter
module tb_toggle_req_arbiter;

    localparam int N  = 4;
    localparam int K  = 2;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_pulse = '0;
    logic         ack_pol = 1'b0;
    logic         tx_pol;
    logic [1:0]   tx_id;
    logic         busy;
    logic [N-1:0] done_pulse;
    logic [N-1:0] pend;
    logic [N-1:0] coalesce_pulse;
    logic         ack_late;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    toggle_req_arbiter #(.N_REQ(N), .ID_W(2), .ACK_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_pulse      (req_pulse),
        .ack_pol        (ack_pol),
        .tx_pol         (tx_pol),
        .tx_id          (tx_id),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .pend           (pend),
        .coalesce_pulse (coalesce_pulse),
        .ack_late       (ack_late)
    );

    // Reference: phase 0 = nothing granted, 1 = granted awaiting flip, 2 = awaiting far-side echo.
    int           m_phase, m_ptr, m_id, m_wait;
    bit           m_pend [N];
    bit           m_pol, m_late;
    bit [N-1:0]   m_done, m_coal;
    bit           pol_hist[$];
    bit           hold;
    int           grants[$];
    bit           prev_busy;
    int           coal0_cnt, done0_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit pend_any();
        return pend_vec() != '0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_id = 0; m_wait = 0;
        m_pol = 0; m_late = 0; m_done = '0; m_coal = '0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    task automatic model_edge(input bit [N-1:0] req, input bit ack);
        int clr;
        bit found;
        clr = -1;
        found = 0;
        m_done = '0;
        m_coal = '0;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                if (!found && m_pend[(m_ptr + k) % N]) begin
                    found = 1;
                    m_id = (m_ptr + k) % N;
                end
            end
            if (found) m_phase = 1;
        end else if (m_phase == 1) begin
            m_pol = !m_pol;
            m_wait = 0;
            m_phase = 2;
        end else begin
            if (ack == m_pol) begin
                m_done[m_id] = 1;
                clr = m_id;
                m_ptr = (m_id + 1) % N;
                m_late = 0;
                m_phase = 0;
            end else begin
                if (m_wait < TO) m_wait++;
                if (m_wait >= TO) m_late = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (m_pend[i] && i != clr) m_coal[i] = 1;
                m_pend[i] = 1;
            end else if (i == clr) begin
                m_pend[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("tx_pol", 32'(tx_pol), 32'(m_pol));
        chk("tx_id", 32'(tx_id), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done_pulse", 32'(done_pulse), 32'(m_done));
        chk("pend", 32'(pend), 32'(pend_vec()));
        chk("coalesce_pulse", 32'(coalesce_pulse), 32'(m_coal));
        chk("ack_late", 32'(ack_late), 32'(m_late));
    endtask

    task automatic clear_hist();
        pol_hist.delete();
        for (int i = 0; i <= K; i++) pol_hist.push_back(1'b0);
    endtask

    task automatic step();
        bit [N-1:0] r;
        bit a;
        r = req_pulse;
        a = ack_pol;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_edge(r, a);
        check_all();
        if (busy && !prev_busy) grants.push_back(int'(tx_id));
        prev_busy = busy;
        if (coalesce_pulse[0]) coal0_cnt++;
        if (done_pulse[0]) done0_cnt++;
        pol_hist.push_front(m_pol);
        void'(pol_hist.pop_back());
        if (!hold) ack_pol = pol_hist[K];
        req_pulse = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ack_pol = 1'b0;
        hold = 0;
        clear_hist();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_phase != 0 || pend_any()) && n < 300) begin
            step();
            n++;
        end
        chk("drain_bound", 32'(n < 300), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fired;
        model_reset();
        clear_hist();
        hold = 0;
        prev_busy = 0;
        coal0_cnt = 0;
        done0_cnt = 0;

        // Reset state
        do_reset();
        chk("rst_pend", 32'(pend), 32'd0);

        // Single request with K=2 loopback
        req_pulse = 4'b0100;
        step(); step(); step();
        chk("sr_pol_flip", 32'(tx_pol), 32'd1);
        step(); step(); step();
        chk("sr_done", 32'(done_pulse), 32'b0100);
        chk("sr_id", 32'(tx_id), 32'd2);
        chk("sr_pend", 32'(pend), 32'd0);
        drain();

        // All pending from pointer 0, then wrap
        do_reset();
        grants.delete();
        req_pulse = 4'b1111;
        step();
        drain();
        chk("all_cnt", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("all_order", 32'(grants.size() > i ? grants[i] : -1), 32'(i));
        chk("all_pol_end", 32'(tx_pol), 32'd0);

        grants.delete();
        req_pulse = 4'b1001;
        step();
        drain();
        chk("wrap_cnt", 32'(grants.size()), 32'd2);
        chk("wrap_first", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
        chk("wrap_second", 32'(grants.size() > 1 ? grants[1] : -1), 32'd3);

        // Set wins over clear
        grants.delete();
        fired = 0;
        req_pulse = 4'b0010;
        for (int n = 0; n < 40 && !fired; n++) begin
            if (m_phase == 2 && ack_pol == m_pol) begin
                req_pulse = 4'b0010;
                fired = 1;
                step();
                chk("sw_pend1", 32'(pend[1]), 32'd1);
                chk("sw_done1", 32'(done_pulse[1]), 32'd1);
            end else begin
                step();
            end
        end
        chk("sw_fired", 32'(fired), 32'd1);
        drain();
        chk("sw_cnt", 32'(grants.size()), 32'd2);
        chk("sw_second_id", 32'(grants.size() > 1 ? grants[1] : -1), 32'd1);

        // Coalesce while waiting
        grants.delete();
        coal0_cnt = 0;
        done0_cnt = 0;
        req_pulse = 4'b0001;
        step(); step(); step();
        req_pulse = 4'b0001;
        step();
        drain();
        chk("co_coal", 32'(coal0_cnt), 32'd1);
        chk("co_done", 32'(done0_cnt), 32'd1);
        chk("co_xfers", 32'(grants.size()), 32'd1);

        // Timeout with held ack, then release
        hold = 1;
        req_pulse = 4'b0100;
        for (int i = 0; i < 10; i++) step();
        chk("to_late_before", 32'(ack_late), 32'd0);
        step();
        chk("to_late_set", 32'(ack_late), 32'd1);
        chk("to_busy", 32'(busy), 32'd1);
        hold = 0;
        step(); step();
        chk("to_late_clr", 32'(ack_late), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_done", 32'(done_pulse), 32'b0100);
        drain();

        // Asynchronous reset in the middle of WAIT_ACK
        hold = 1;
        req_pulse = 4'b1000;
        step(); step(); step(); step();
        chk("ar_busy_pre", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("ar_tx_pol", 32'(tx_pol), 32'd0);
        chk("ar_tx_id", 32'(tx_id), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done_pulse), 32'd0);
        chk("ar_pend", 32'(pend), 32'd0);
        chk("ar_coal", 32'(coalesce_pulse), 32'd0);
        chk("ar_late", 32'(ack_late), 32'd0);
        ack_pol = 1'b0;
        clear_hist();
        hold = 0;
        model_reset();
        step();
        rst = 1'b0;
        step();

        // Randomized traffic with occasional stalled acknowledge
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 2) == 0) req_pulse = N'($urandom);
            if ($urandom_range(0, 15) == 0) hold = !hold;
            step();
        end
        hold = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
